// File: rtl/level_meter_pkg.sv
// Shared register map for the level meter. The CPU header generator and the
// bench both import these addresses.
package level_meter_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_PEAK = 2'd1;
  localparam logic [1:0] ADDR_MEAN = 2'd2;
  localparam logic [1:0] ADDR_CLIP = 2'd3;

endpackage

// File: rtl/level_meter_abs_sat.sv
// Combinational saturating magnitude of a signed sample, plus a full-scale flag.
// The most negative code has no positive twin, so it maps to the largest magnitude.
module abs_sat #(
  parameter int A_WDT = 16
) (
  input  logic [A_WDT-1:0] a,
  output logic [A_WDT-2:0] mag,
  output logic             clip
);

  localparam logic signed [A_WDT-1:0] S_MAX   = {1'b0, {(A_WDT-1){1'b1}}};
  localparam logic signed [A_WDT-1:0] S_MIN   = {1'b1, {(A_WDT-1){1'b0}}};
  localparam logic [A_WDT-2:0]        MAG_MAX = {(A_WDT-1){1'b1}};

  function automatic logic [A_WDT-2:0] sat_abs(input logic signed [A_WDT-1:0] x);
    logic signed [A_WDT-1:0] n;
    n = -x;
    if (x == S_MIN)
      sat_abs = MAG_MAX;
    else if (x[A_WDT-1])
      sat_abs = n[A_WDT-2:0];
    else
      sat_abs = x[A_WDT-2:0];
  endfunction

  logic signed [A_WDT-1:0] a_s;

  assign a_s  = a;
  assign mag  = sat_abs(a_s);
  assign clip = (a_s == S_MAX) || (a_s == S_MIN);

endmodule

// File: rtl/level_meter.sv
// Windowed peak / mean |a| meter with a saturating full-scale counter,
// exposed through a small Avalon-MM register window and a per-window strobe.
module level_meter
  import level_meter_pkg::*;
#(
  parameter int A_WDT    = 16,
  parameter int WIN_LOG2 = 10,
  parameter int CLIP_WDT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         avsAddr,
  input  logic               avsWr,
  input  logic [31:0]        avsWrData,
  output logic [31:0]        avsRdData,
  input  logic               st,
  input  logic [A_WDT-1:0]   a,
  output logic               rdy,
  output logic [A_WDT-2:0]   peak,
  output logic [A_WDT-2:0]   mean
);

  localparam int ACC_W = A_WDT - 1 + WIN_LOG2;

  function automatic logic [A_WDT-2:0] trunc_mean(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] q;
    q = sum >> WIN_LOG2;
    trunc_mean = q[A_WDT-2:0];
  endfunction

  function automatic logic [CLIP_WDT-1:0] sat_inc(input logic [CLIP_WDT-1:0] c);
    sat_inc = (c == {CLIP_WDT{1'b1}}) ? c : c + CLIP_WDT'(1);
  endfunction

  logic                enable;
  logic                ctrl_wr;
  logic                clr_clip;
  logic                dis;

  logic [A_WDT-2:0]    mag_p0;
  logic                clip_p0;

  logic                vld_p1;
  logic [A_WDT-2:0]    abs_p1;
  logic                clip_p1;

  logic [WIN_LOG2-1:0] cnt_p2;
  logic [ACC_W-1:0]    acc_p2;
  logic [A_WDT-2:0]    run_peak_p2;
  logic [CLIP_WDT-1:0] clip_cnt_p2;

  logic [ACC_W-1:0]    acc_sum;
  logic [A_WDT-2:0]    peak_new;
  logic                win_end;

  // Writing enable=0 flushes the partial window regardless of prior state.
  assign ctrl_wr  = avsWr && (avsAddr == ADDR_CTRL);
  assign clr_clip = ctrl_wr && avsWrData[1];
  assign dis      = ctrl_wr && !avsWrData[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      enable <= 1'b0;
    else if (ctrl_wr)
      enable <= avsWrData[0];
  end

  abs_sat #(.A_WDT(A_WDT)) u_abs_sat (
    .a    (a),
    .mag  (mag_p0),
    .clip (clip_p0)
  );

  // Stage 1: register magnitude and clip flag of an accepted sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      abs_p1  <= '0;
      clip_p1 <= 1'b0;
    end else begin
      vld_p1 <= st && enable && !dis;
      if (st && enable) begin
        abs_p1  <= mag_p0;
        clip_p1 <= clip_p0;
      end
    end
  end

  assign acc_sum  = acc_p2 + ACC_W'(abs_p1);
  assign peak_new = (abs_p1 > run_peak_p2) ? abs_p1 : run_peak_p2;
  assign win_end  = vld_p1 && (cnt_p2 == {WIN_LOG2{1'b1}});

  // Stage 2: running window state, window results and clip counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p2      <= '0;
      acc_p2      <= '0;
      run_peak_p2 <= '0;
      peak        <= '0;
      mean        <= '0;
      rdy         <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (dis) begin
        cnt_p2      <= '0;
        acc_p2      <= '0;
        run_peak_p2 <= '0;
      end else if (vld_p1) begin
        cnt_p2 <= cnt_p2 + WIN_LOG2'(1);
        if (win_end) begin
          acc_p2      <= '0;
          run_peak_p2 <= '0;
          peak        <= peak_new;
          mean        <= trunc_mean(acc_sum);
          rdy         <= 1'b1;
        end else begin
          acc_p2      <= acc_sum;
          run_peak_p2 <= peak_new;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      clip_cnt_p2 <= '0;
    else if (clr_clip)
      clip_cnt_p2 <= '0;
    else if (vld_p1 && clip_p1)
      clip_cnt_p2 <= sat_inc(clip_cnt_p2);
  end

  always_comb begin
    avsRdData = '0;
    case (avsAddr)
      ADDR_CTRL: avsRdData = {31'd0, enable};
      ADDR_PEAK: avsRdData = 32'(peak);
      ADDR_MEAN: avsRdData = 32'(mean);
      ADDR_CLIP: avsRdData = 32'(clip_cnt_p2);
      default:   avsRdData = '0;
    endcase
  end

endmodule

// File: tb/tb_level_meter.sv
// Directed bench for level_meter: a reference model pushes expected window
// results when the closing sample is driven; a monitor pops them on rdy.
module tb_level_meter;
  import level_meter_pkg::*;

  localparam int A_WDT    = 16;
  localparam int WIN_LOG2 = 2;
  localparam int CLIP_WDT = 4;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int CLIP_MAX = (1 << CLIP_WDT) - 1;

  logic              clk;
  logic              reset;
  logic [1:0]        avsAddr;
  logic              avsWr;
  logic [31:0]       avsWrData;
  logic [31:0]       avsRdData;
  logic              st;
  logic [A_WDT-1:0]  a;
  logic              rdy;
  logic [A_WDT-2:0]  peak;
  logic [A_WDT-2:0]  mean;

  level_meter #(.A_WDT(A_WDT), .WIN_LOG2(WIN_LOG2), .CLIP_WDT(CLIP_WDT)) dut (
    .clk       (clk),
    .reset     (reset),
    .avsAddr   (avsAddr),
    .avsWr     (avsWr),
    .avsWrData (avsWrData),
    .avsRdData (avsRdData),
    .st        (st),
    .a         (a),
    .rdy       (rdy),
    .peak      (peak),
    .mean      (mean)
  );

  typedef struct {
    int pk;
    int mn;
    int due;
  } exp_t;

  exp_t sbq[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int m_en   = 0;
  int m_cnt  = 0;
  int m_sum  = 0;
  int m_pk   = 0;
  int m_clip = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy) begin
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rdy cycle=%0d got rdy=1 required rdy=0", cyc);
      end
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        checks++;
        assert (int'(peak) === e.pk) else begin
          errors++;
          $error("FAIL rdy_peak got %0d required %0d", peak, e.pk);
        end
        checks++;
        assert (int'(mean) === e.mn) else begin
          errors++;
          $error("FAIL rdy_mean got %0d required %0d", mean, e.mn);
        end
        checks++;
        assert (cyc === e.due) else begin
          errors++;
          $error("FAIL rdy_latency got cycle %0d required cycle %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic idle_inputs();
    st        = 1'b0;
    a         = '0;
    avsWr     = 1'b0;
    avsAddr   = ADDR_CTRL;
    avsWrData = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
    end
  endtask

  task automatic send(input int v);
    int mag;
    @(negedge clk);
    idle_inputs();
    st = 1'b1;
    a  = 16'(v);
    if (m_en != 0) begin
      mag = (v == -32768) ? 32767 : ((v < 0) ? -v : v);
      m_sum += mag;
      if (mag > m_pk) m_pk = mag;
      m_cnt++;
      if ((v == 32767 || v == -32768) && m_clip < CLIP_MAX) m_clip++;
      if (m_cnt == WIN) begin
        sbq.push_back('{pk: m_pk, mn: m_sum >> WIN_LOG2, due: cyc + 2});
        m_cnt = 0;
        m_sum = 0;
        m_pk  = 0;
      end
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] d);
    @(negedge clk);
    idle_inputs();
    avsWr     = 1'b1;
    avsAddr   = addr;
    avsWrData = d;
    if (addr == ADDR_CTRL) begin
      m_en = int'(d[0]);
      if (d[1]) m_clip = 0;
      if (!d[0]) begin
        m_cnt = 0;
        m_sum = 0;
        m_pk  = 0;
      end
    end
  endtask

  task automatic rd_now(input logic [1:0] addr, input int exp, input string tag);
    avsAddr = addr;
    #1;
    checks++;
    assert (int'(avsRdData) === exp) else begin
      errors++;
      $error("FAIL %s got %0d required %0d", tag, avsRdData, exp);
    end
  endtask

  task automatic rd(input logic [1:0] addr, input int exp, input string tag);
    @(negedge clk);
    idle_inputs();
    rd_now(addr, exp, tag);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset: every register and output reads zero.
    rd(ADDR_CTRL, 0, "reset_ctrl");
    rd(ADDR_PEAK, 0, "reset_peak");
    rd(ADDR_MEAN, 0, "reset_mean");
    rd(ADDR_CLIP, 0, "reset_clip");
    checks++;
    assert (rdy === 1'b0 && peak === '0 && mean === '0) else begin
      errors++;
      $error("FAIL reset_outputs got rdy=%0d peak=%0d mean=%0d required all 0", rdy, peak, mean);
    end
    @(negedge clk);
    reset = 1'b0;

    // Samples while disabled are ignored.
    for (int i = 0; i < 4; i++) send(5000);
    idle(3);
    rd(ADDR_PEAK, 0, "disabled_peak");

    // Basic window.
    wr(ADDR_CTRL, 32'd1);
    send(100); send(-300); send(50); send(-2);
    idle(3);
    rd(ADDR_PEAK, 300, "basic_peak");
    rd(ADDR_MEAN, 113, "basic_mean");
    rd(ADDR_CLIP, 0, "basic_clip");
    rd(ADDR_CTRL, 1, "ctrl_enable");

    // Saturating abs and clip flags.
    send(-32768); send(32767); send(0); send(0);
    idle(3);
    rd(ADDR_PEAK, 32767, "sat_peak");
    rd(ADDR_MEAN, 16383, "sat_mean");
    rd(ADDR_CLIP, 2, "sat_clip");

    // Clip counter saturation, then clear coincident with a clipped S2 sample.
    for (int i = 0; i < 20; i++) send(32767);
    idle(3);
    rd(ADDR_CLIP, CLIP_MAX, "clip_saturate");
    send(32767);
    wr(ADDR_CTRL, 32'd3);
    idle(2);
    rd(ADDR_CLIP, m_clip, "clip_clear_wins");
    rd(ADDR_CTRL, 1, "ctrl_clr_reads_0");

    // Disable mid-window discards the partial window.
    send(1000); send(1000);
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_CTRL, 32'd1);
    for (int i = 0; i < 4; i++) send(8);
    idle(3);
    rd(ADDR_PEAK, 8, "disable_peak");
    rd(ADDR_MEAN, 8, "disable_mean");

    // Back-to-back samples every cycle.
    for (int i = 1; i <= 12; i++) send(i);
    idle(4);
    rd(ADDR_PEAK, 12, "b2b_peak");
    rd(ADDR_MEAN, 10, "b2b_mean");

    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL missing_rdy got %0d pending windows required 0", sbq.size());
    end

    // Asynchronous reset mid-window: values clear without a clock edge.
    send(700); send(700);
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b1;
    m_en = 0; m_cnt = 0; m_sum = 0; m_pk = 0; m_clip = 0;
    rd_now(ADDR_PEAK, 0, "async_reset_peak");
    rd_now(ADDR_CTRL, 0, "async_reset_ctrl");
    idle(2);
    reset = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
